// File: rtl/imem_boot_loader.sv
// Boot sequencer: streams a host program into instruction memory while holding the CPU in reset.
// Optional XOR checksum of loaded words is enabled by defining LOADER_CHECKSUM_EN.
module imem_boot_loader #(
  parameter int          MAX_WORDS = 16,
  parameter logic [31:0] BASE_ADDR = 32'd0,
  parameter int          RUN_HOLD  = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           host_valid,
  input  logic [31:0]                    host_data,
  input  logic                           host_last,
  output logic                           host_ready,
  output logic                           cpu_rst,
  output logic                           initialize,
  output logic [31:0]                    instruction_initialize_data,
  output logic [31:0]                    instruction_initialize_address,
  output logic                           busy,
  output logic                           done,
  output logic [$clog2(MAX_WORDS+1)-1:0] word_count,
  output logic                           truncated,
  output logic [31:0]                    checksum
);

  localparam int CW = $clog2(MAX_WORDS + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_RUN  = 2'd3;

  localparam logic [CW-1:0] MAX_CNT   = CW'(MAX_WORDS);
  localparam logic [7:0]    HOLD_INIT = 8'(RUN_HOLD);

  logic [1:0]    r_state;
  logic [CW-1:0] r_count;
  logic [7:0]    r_hold;
  logic          r_cpu_rst;
  logic          r_init;
  logic [31:0]   r_data;
  logic [31:0]   r_addr;
  logic          r_busy;
  logic          r_done;
  logic          r_trunc;

  logic          w_accept;
  logic          w_restart;
  logic          w_full_next;

  assign host_ready  = (r_state == S_LOAD) && (r_count < MAX_CNT);
  assign w_accept    = host_valid && host_ready;
  assign w_restart   = start && ((r_state == S_IDLE) || (r_state == S_RUN));
  assign w_full_next = (r_count + 1'b1) == MAX_CNT;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_hold    <= '0;
      r_cpu_rst <= 1'b1;
      r_init    <= 1'b0;
      r_data    <= '0;
      r_addr    <= BASE_ADDR;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_trunc   <= 1'b0;
    end else begin
      r_init <= 1'b0;
      case (r_state)
        S_IDLE, S_RUN: begin
          if (w_restart) begin
            r_state   <= S_LOAD;
            r_cpu_rst <= 1'b1;
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
            r_count   <= '0;
            r_trunc   <= 1'b0;
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            r_init  <= 1'b1;
            r_data  <= host_data;
            r_addr  <= BASE_ADDR + (32'(r_count) << 2);
            r_count <= r_count + 1'b1;
            // host_last wins over a simultaneous fill, so truncation is only flagged without it
            if (host_last || w_full_next) begin
              r_state <= S_HOLD;
              r_hold  <= HOLD_INIT;
              r_trunc <= !host_last;
            end
          end
        end
        S_HOLD: begin
          // Leaving on count 1 makes RUN start exactly RUN_HOLD cycles after the final write
          if (r_hold <= 8'd1) begin
            r_state   <= S_RUN;
            r_cpu_rst <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
          end else begin
            r_hold <= r_hold - 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] r_checksum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_checksum <= '0;
    end else if (w_restart) begin
      r_checksum <= '0;
    end else if (w_accept) begin
      r_checksum <= r_checksum ^ host_data;
    end
  end

  assign checksum = r_checksum;
`else
  assign checksum = 32'd0;
`endif

  assign cpu_rst                        = r_cpu_rst;
  assign initialize                     = r_init;
  assign instruction_initialize_data    = r_data;
  assign instruction_initialize_address = r_addr;
  assign busy                           = r_busy;
  assign done                           = r_done;
  assign word_count                     = r_count;
  assign truncated                      = r_trunc;

endmodule
